// File: rtl/lsu_dmem_arbiter.sv
// Shares one single-port, synchronous-read data memory between the two LSU lanes.
// A bundle with two memory ops is serialised lane 0 first, and the pipeline stalls until the bundle completes.
module lsu_dmem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clock_i,
    input  logic              reset_ni,

    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [31:0]       addr0_i,
    input  logic [31:0]       wdata0_i,
    input  logic [3:0]        wmask0_i,

    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [31:0]       addr1_i,
    input  logic [31:0]       wdata1_i,
    input  logic [3:0]        wmask1_i,

    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic              dmem_re_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_wmask_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic [31:0]       dmem_rdata_i,

    output logic [31:0]       rdata0_o,
    output logic [31:0]       rdata1_o,
    output logic              mem_stall_o,

    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SECOND = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] cap0_q, cap0_d;

    logic        load0, load1, dual;
    logic        issue, issue_lane1;

    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_wmask;

    // Only the word-address bits reach the memory; byte offset is resolved by mask and writeback.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{addr0_i[31:ADDR_W+2], addr0_i[1:0],
                                addr1_i[31:ADDR_W+2], addr1_i[1:0]};

    // The pipeline holds these inputs stable through the whole bundle, DRAIN included.
    assign load0 = req0_i & ~we0_i;
    assign load1 = req1_i & ~we1_i;
    assign dual  = req0_i & req1_i;

    always_comb begin
        state_d     = state_q;
        cap0_d      = cap0_q;
        issue       = 1'b0;
        issue_lane1 = 1'b0;
        mem_stall_o = 1'b0;
        rdata0_o    = 32'd0;
        rdata1_o    = 32'd0;
        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    issue       = 1'b1;
                    issue_lane1 = ~req0_i;
                    mem_stall_o = 1'b1;
                    state_d     = dual ? ST_SECOND : ST_DRAIN;
                end
            end
            ST_SECOND: begin
                issue       = 1'b1;
                issue_lane1 = 1'b1;
                mem_stall_o = 1'b1;
                cap0_d      = load0 ? dmem_rdata_i : 32'd0;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The last-issued lane's data arrives now; a dual bundle's lane 0 data was captured in SECOND.
                rdata1_o = load1 ? dmem_rdata_i : 32'd0;
                if (dual) begin
                    rdata0_o = load0 ? cap0_q : 32'd0;
                end else begin
                    rdata0_o = load0 ? dmem_rdata_i : 32'd0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        sel_we    = issue_lane1 ? we1_i    : we0_i;
        sel_addr  = issue_lane1 ? addr1_i  : addr0_i;
        sel_wdata = issue_lane1 ? wdata1_i : wdata0_i;
        sel_wmask = issue_lane1 ? wmask1_i : wmask0_i;

        dmem_re_o    = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_wmask_o = 4'd0;
        dmem_wdata_o = 32'd0;
        dmem_addr_o  = '0;
        if (issue) begin
            dmem_addr_o = sel_addr[ADDR_W+1:2];
            dmem_re_o   = ~sel_we;
            dmem_we_o   = sel_we;
            if (sel_we) begin
                dmem_wmask_o = sel_wmask;
                dmem_wdata_o = sel_wdata;
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            cap0_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cap0_q  <= cap0_d;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsu_dmem_arbiter.sv
// Bench for lsu_dmem_arbiter: a synchronous-read memory model on the port, a reference
// memory that predicts load results in program order, and an expected-result queue.
module tb_lsu_dmem_arbiter;

    localparam int ADDR_W = 10;

    logic              clock_i = 1'b0;
    logic              reset_ni = 1'b0;
    logic              req0_i, we0_i, req1_i, we1_i;
    logic [31:0]       addr0_i, wdata0_i, addr1_i, wdata1_i;
    logic [3:0]        wmask0_i, wmask1_i;
    logic [ADDR_W-1:0] dmem_addr_o;
    logic              dmem_re_o, dmem_we_o;
    logic [3:0]        dmem_wmask_o;
    logic [31:0]       dmem_wdata_o;
    logic [31:0]       dmem_rdata_i;
    logic [31:0]       rdata0_o, rdata1_o;
    logic              mem_stall_o;
    logic [1:0]        dbg_state_o;

    logic [31:0]       mem [0:1023];
    logic [31:0]       ref_mem [0:1023];
    logic [63:0]       exp_q[$];

    logic              bd_we = 1'b0;
    logic [9:0]        bd_addr = '0;
    logic [31:0]       bd_data = '0;

    int errors = 0;
    int checks = 0;

    lsu_dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clock_i      (clock_i),
        .reset_ni     (reset_ni),
        .req0_i       (req0_i),
        .we0_i        (we0_i),
        .addr0_i      (addr0_i),
        .wdata0_i     (wdata0_i),
        .wmask0_i     (wmask0_i),
        .req1_i       (req1_i),
        .we1_i        (we1_i),
        .addr1_i      (addr1_i),
        .wdata1_i     (wdata1_i),
        .wmask1_i     (wmask1_i),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_re_o    (dmem_re_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_wmask_o (dmem_wmask_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .rdata0_o     (rdata0_o),
        .rdata1_o     (rdata1_o),
        .mem_stall_o  (mem_stall_o),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- clock ----------------
    always #5 clock_i = ~clock_i;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // ---------------- memory model ----------------
    always @(posedge clock_i) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (dmem_re_o) dmem_rdata_i <= mem[dmem_addr_o];
        if (dmem_we_o) mem[dmem_addr_o] <= merge(mem[dmem_addr_o], dmem_wdata_o, dmem_wmask_o);
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic set_inputs(input logic r0, input logic w0, input logic [31:0] a0,
                              input logic [31:0] d0, input logic [3:0] m0,
                              input logic r1, input logic w1, input logic [31:0] a1,
                              input logic [31:0] d1, input logic [3:0] m1);
        req0_i = r0; we0_i = w0; addr0_i = a0; wdata0_i = d0; wmask0_i = m0;
        req1_i = r1; we1_i = w1; addr1_i = a1; wdata1_i = d1; wmask1_i = m1;
    endtask

    task automatic clear_inputs();
        set_inputs(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic poke(input int w, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = w[9:0]; bd_data = d;
        ref_mem[w] = d;
        @(posedge clock_i); #1;
        bd_we = 1'b0;
    endtask

    // Drives a bundle and predicts both lanes' load results in program order.
    task automatic drive_bundle(input logic r0, input logic w0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic [3:0] m0,
                                input logic r1, input logic w1, input logic [31:0] a1,
                                input logic [31:0] d1, input logic [3:0] m1);
        logic [31:0] e0, e1;
        e0 = 32'd0;
        e1 = 32'd0;
        set_inputs(r0, w0, a0, d0, m0, r1, w1, a1, d1, m1);
        if (r0) begin
            if (w0) ref_mem[a0[11:2]] = merge(ref_mem[a0[11:2]], d0, m0);
            else    e0 = ref_mem[a0[11:2]];
        end
        if (r1) begin
            if (w1) ref_mem[a1[11:2]] = merge(ref_mem[a1[11:2]], d1, m1);
            else    e1 = ref_mem[a1[11:2]];
        end
        exp_q.push_back({e0, e1});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reset_ni = 1'b0;
        @(negedge clock_i);
        checks++;
        if ({dmem_re_o, dmem_we_o, dmem_wmask_o, dmem_addr_o, dmem_wdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_port: re=%b we=%b mask=%h addr=%h wdata=%h, required all 0",
                     dmem_re_o, dmem_we_o, dmem_wmask_o, dmem_addr_o, dmem_wdata_o);
        end
        checks++;
        if (rdata0_o !== 32'd0 || rdata1_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata: rdata0=%h rdata1=%h, required 0", rdata0_o, rdata1_o);
        end
        checks++;
        if (mem_stall_o !== 1'b0 || dbg_state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: stall=%b state=%0d, required 0/IDLE", mem_stall_o, dbg_state_o);
        end
        @(posedge clock_i); #1;
        reset_ni = 1'b1;
        for (int w = 0; w < 16; w++) poke(w, $urandom);
    endtask

    task automatic test_single_load();
        logic [63:0] e;
        poke(32'h10, 32'hDEADBEEF);
        drive_bundle(1'b1, 1'b0, 32'h40, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clock_i);
        checks++;
        if (dmem_addr_o !== 10'h010 || dmem_re_o !== 1'b1 || dmem_we_o !== 1'b0 || mem_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: addr=%h re=%b we=%b stall=%b, required 010/1/0/1",
                     dmem_addr_o, dmem_re_o, dmem_we_o, mem_stall_o);
        end
        @(negedge clock_i);
        e = exp_q.pop_front();
        checks++;
        if (mem_stall_o !== 1'b0 || dbg_state_o !== 2'd2 || dmem_re_o !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: stall=%b state=%0d re=%b, required 0/DRAIN/0",
                     mem_stall_o, dbg_state_o, dmem_re_o);
        end
        checks++;
        if (rdata0_o !== e[63:32] || rdata1_o !== e[31:0] || rdata0_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_rdata: rdata0=%h rdata1=%h, required %h %h", rdata0_o, rdata1_o,
                     e[63:32], e[31:0]);
        end
        @(posedge clock_i); #1;
        clear_inputs();
    endtask

    task automatic test_dual_loads();
        logic [63:0] e;
        poke(0, 32'h11);
        poke(1, 32'h22);
        drive_bundle(1'b1, 1'b0, 32'h0, 32'd0, 4'd0, 1'b1, 1'b0, 32'h4, 32'd0, 4'd0);
        @(negedge clock_i);
        checks++;
        if (dmem_addr_o !== 10'h000 || dmem_re_o !== 1'b1 || mem_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL dual_first: addr=%h re=%b stall=%b, required 000/1/1", dmem_addr_o, dmem_re_o, mem_stall_o);
        end
        @(negedge clock_i);
        checks++;
        if (dmem_addr_o !== 10'h001 || dmem_re_o !== 1'b1 || mem_stall_o !== 1'b1 ||
            dbg_state_o !== 2'd1 || rdata0_o !== 32'd0) begin
            errors++;
            $display("FAIL dual_second: addr=%h re=%b stall=%b state=%0d rdata0=%h, required 001/1/1/SECOND/0",
                     dmem_addr_o, dmem_re_o, mem_stall_o, dbg_state_o, rdata0_o);
        end
        @(negedge clock_i);
        e = exp_q.pop_front();
        checks++;
        if (mem_stall_o !== 1'b0 || rdata0_o !== e[63:32] || rdata1_o !== e[31:0] ||
            rdata0_o !== 32'h11 || rdata1_o !== 32'h22) begin
            errors++;
            $display("FAIL dual_rdata: stall=%b rdata0=%h rdata1=%h, required 0 %h %h",
                     mem_stall_o, rdata0_o, rdata1_o, e[63:32], e[31:0]);
        end
        @(posedge clock_i); #1;
        clear_inputs();
    endtask

    task automatic test_store_load_order();
        logic [63:0] e;
        drive_bundle(1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h80, 32'd0, 4'd0);
        @(negedge clock_i);
        checks++;
        if (dmem_we_o !== 1'b1 || dmem_re_o !== 1'b0 || dmem_addr_o !== 10'h020 ||
            dmem_wmask_o !== 4'hF || dmem_wdata_o !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL st_ld_write: we=%b re=%b addr=%h mask=%h wdata=%h, required 1/0/020/f/cafef00d",
                     dmem_we_o, dmem_re_o, dmem_addr_o, dmem_wmask_o, dmem_wdata_o);
        end
        @(negedge clock_i);
        checks++;
        if (dmem_re_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_wmask_o !== 4'd0 || dmem_addr_o !== 10'h020) begin
            errors++;
            $display("FAIL st_ld_read: re=%b we=%b mask=%h addr=%h, required 1/0/0/020",
                     dmem_re_o, dmem_we_o, dmem_wmask_o, dmem_addr_o);
        end
        @(negedge clock_i);
        e = exp_q.pop_front();
        checks++;
        if (rdata0_o !== e[63:32] || rdata1_o !== e[31:0] || rdata1_o !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL st_ld_rdata: rdata0=%h rdata1=%h, required %h %h", rdata0_o, rdata1_o, e[63:32], e[31:0]);
        end
        @(posedge clock_i); #1;
        // Load then store to the same word: the load sees the old value.
        drive_bundle(1'b1, 1'b0, 32'h80, 32'd0, 4'd0, 1'b1, 1'b1, 32'h80, 32'h12345678, 4'hF);
        @(negedge clock_i);
        @(negedge clock_i);
        @(negedge clock_i);
        e = exp_q.pop_front();
        checks++;
        if (rdata0_o !== e[63:32] || rdata1_o !== e[31:0] || rdata0_o !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL ld_st_rdata: rdata0=%h rdata1=%h, required %h %h", rdata0_o, rdata1_o, e[63:32], e[31:0]);
        end
        @(posedge clock_i); #1;
        clear_inputs();
        checks++;
        if (mem[32'h20] !== 32'h12345678) begin
            errors++;
            $display("FAIL ld_st_mem: mem=%h, required 12345678", mem[32'h20]);
        end
    endtask

    task automatic test_lane1_store();
        logic [63:0] e;
        poke(32'h41, 32'hFFFFFFFF);
        drive_bundle(1'b0, 1'b1, 32'h200, 32'h55, 4'hF, 1'b1, 1'b1, 32'h104, 32'h000000AB, 4'h1);
        @(negedge clock_i);
        checks++;
        if (dmem_addr_o !== 10'h041 || dmem_we_o !== 1'b1 || dmem_wmask_o !== 4'h1 ||
            dmem_re_o !== 1'b0 || dmem_wdata_o !== 32'hAB || mem_stall_o !== 1'b1) begin
            errors++;
            $display("FAIL l1_store_port: addr=%h we=%b mask=%h re=%b wdata=%h stall=%b, required 041/1/1/0/ab/1",
                     dmem_addr_o, dmem_we_o, dmem_wmask_o, dmem_re_o, dmem_wdata_o, mem_stall_o);
        end
        @(negedge clock_i);
        e = exp_q.pop_front();
        checks++;
        if (mem_stall_o !== 1'b0 || dmem_we_o !== 1'b0 || rdata0_o !== e[63:32] || rdata1_o !== e[31:0]) begin
            errors++;
            $display("FAIL l1_store_drain: stall=%b we=%b rdata0=%h rdata1=%h, required 0/0/%h/%h",
                     mem_stall_o, dmem_we_o, rdata0_o, rdata1_o, e[63:32], e[31:0]);
        end
        @(posedge clock_i); #1;
        clear_inputs();
        checks++;
        if (mem[32'h41] !== ref_mem[32'h41] || mem[32'h41] !== 32'hFFFFFFAB) begin
            errors++;
            $display("FAIL l1_store_mem: mem=%h, required ffffffab", mem[32'h41]);
        end
        // Misaligned lane 1 load with a deasserted lane 0 carrying store controls.
        drive_bundle(1'b0, 1'b1, 32'h200, 32'h55, 4'hF, 1'b1, 1'b0, 32'h0B, 32'd0, 4'd0);
        @(negedge clock_i);
        checks++;
        if (dmem_addr_o !== 10'h002 || dmem_re_o !== 1'b1 || dmem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL ignored_req: addr=%h re=%b we=%b, required 002/1/0", dmem_addr_o, dmem_re_o, dmem_we_o);
        end
        @(negedge clock_i);
        e = exp_q.pop_front();
        checks++;
        if (rdata0_o !== e[63:32] || rdata1_o !== e[31:0]) begin
            errors++;
            $display("FAIL ignored_rdata: rdata0=%h rdata1=%h, required %h %h", rdata0_o, rdata1_o, e[63:32], e[31:0]);
        end
        @(posedge clock_i); #1;
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        logic [63:0] e;
        for (int b = 0; b < 2; b++) begin
            drive_bundle(1'b1, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'd0},
                         $urandom, 4'hF,
                         1'b1, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'd0},
                         $urandom, 4'hF);
            for (int c = 0; c < 3; c++) begin
                @(negedge clock_i);
                pat[5 - (3 * b + c)] = mem_stall_o;
            end
            e = exp_q.pop_front();
            checks++;
            if (rdata0_o !== e[63:32] || rdata1_o !== e[31:0]) begin
                errors++;
                $display("FAIL b2b_rdata%0d: rdata0=%h rdata1=%h, required %h %h", b,
                         rdata0_o, rdata1_o, e[63:32], e[31:0]);
            end
            @(posedge clock_i); #1;
        end
        clear_inputs();
        checks++;
        if (pat !== 6'b110110) begin
            errors++;
            $display("FAIL b2b_stall: pattern=%b, required 110110", pat);
        end
    endtask

    task automatic test_random();
        logic r0, r1;
        logic [63:0] e;
        int n;
        for (int i = 0; i < 24; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_bundle(r0, 1'($urandom_range(0, 1)),
                         {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                         $urandom, 4'($urandom_range(1, 15)),
                         r1, 1'($urandom_range(0, 1)),
                         {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
                         $urandom, 4'($urandom_range(1, 15)));
            n = 0;
            @(negedge clock_i);
            while (mem_stall_o === 1'b1 && n < 5) begin
                n++;
                @(negedge clock_i);
            end
            e = exp_q.pop_front();
            checks++;
            if (n !== ((r0 && r1) ? 2 : 1)) begin
                errors++;
                $display("FAIL rand_stall%0d: stall_cycles=%0d, required %0d", i, n, (r0 && r1) ? 2 : 1);
            end
            checks++;
            if (rdata0_o !== e[63:32] || rdata1_o !== e[31:0]) begin
                errors++;
                $display("FAIL rand_rdata%0d: rdata0=%h rdata1=%h, required %h %h", i,
                         rdata0_o, rdata1_o, e[63:32], e[31:0]);
            end
            @(posedge clock_i); #1;
            clear_inputs();
        end
    endtask

    task automatic test_reset_second();
        poke(32'hC0, 32'd0);
        poke(32'hC1, 32'd0);
        set_inputs(1'b1, 1'b1, 32'h300, 32'h55, 4'hF, 1'b1, 1'b1, 32'h304, 32'h66, 4'hF);
        ref_mem[32'hC0] = 32'h55;
        @(negedge clock_i);
        @(negedge clock_i);
        checks++;
        if (dbg_state_o !== 2'd1 || dmem_addr_o !== 10'h0C1 || dmem_we_o !== 1'b1) begin
            errors++;
            $display("FAIL rst2_second: state=%0d addr=%h we=%b, required SECOND/0c1/1",
                     dbg_state_o, dmem_addr_o, dmem_we_o);
        end
        reset_ni = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (dbg_state_o !== 2'd0 || dmem_we_o !== 1'b0 || dmem_re_o !== 1'b0 || mem_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst2_abort: state=%0d we=%b re=%b stall=%b, required IDLE/0/0/0",
                     dbg_state_o, dmem_we_o, dmem_re_o, mem_stall_o);
        end
        @(posedge clock_i); #1;
        @(posedge clock_i); #1;
        reset_ni = 1'b1;
        checks++;
        if (mem[32'hC0] !== 32'h55 || mem[32'hC1] !== 32'd0) begin
            errors++;
            $display("FAIL rst2_mem: lane0 word=%h lane1 word=%h, required 55 0", mem[32'hC0], mem[32'hC1]);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        clear_inputs();
        test_reset();
        test_single_load();
        test_dual_loads();
        test_store_load_order();
        test_lane1_store();
        test_back_to_back();
        test_random();
        test_reset_second();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL queue_empty: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
